// File: rtl/lifo_pkg.sv
// ============================================================================
//  Module      : lifo_pkg
//  Description : Shared defaults, counter width derivation and FSM encoding
//                for the LIFO burst reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lifo_pkg;

  localparam int c_DATA_W_DEF    = 2;
  localparam int c_LIFO_SIZE_DEF = 6;

  // Counter must hold every value 0..LIFO_SIZE inclusive.
  function automatic int lifo_cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int             c_ST_W     = 2;
  localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
  localparam logic [c_ST_W-1:0] c_ST_POP   = 2'd1;
  localparam logic [c_ST_W-1:0] c_ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lifo_out_reg.sv
// ============================================================================
//  Module      : lifo_out_reg
//  Description : Output beat register; holds data/last under backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lifo_out_reg #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  // A load only happens when the slot is empty or being drained this cycle,
  // so data/last never change while a beat is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
      r_last  <= load_last;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign last  = r_last;

endmodule

`default_nettype wire

// File: rtl/lifo_reader.sv
// ============================================================================
//  Module      : lifo_reader
//  Description : Pops a burst of len entries from a LIFO onto a ready/valid
//                stream, flagging underrun if the LIFO empties early.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lifo_reader
  import lifo_pkg::*;
#(
  parameter int   DATA_W    = c_DATA_W_DEF,
  parameter int   LIFO_SIZE = c_LIFO_SIZE_DEF,
  localparam int  CNT_W     = lifo_cnt_w(LIFO_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              lifo_read,
  input  logic              lifo_val,
  input  logic [DATA_W-1:0] lifo_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic              underrun
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [c_ST_W-1:0] r_state;
  logic [c_ST_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_done;
  logic              r_underrun;

  logic w_start_ok;
  logic w_zero_start;
  logic w_underrun_ev;
  logic w_last_hs;
  logic w_rem_one;

  assign w_rem_one = (r_remaining == c_CNT_ONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = c_ST_POP;
        end
      end
      c_ST_POP: begin
        if (lifo_read && w_rem_one) begin
          w_state_nxt = c_ST_DRAIN;
        end else if (w_underrun_ev) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_DRAIN: begin
        if (w_last_hs) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    busy          = (r_state != c_ST_IDLE);
    w_start_ok    = (r_state == c_ST_IDLE) && start && (len != '0);
    w_zero_start  = (r_state == c_ST_IDLE) && start && (len == '0);
    lifo_read     = (r_state == c_ST_POP) && lifo_val && (r_remaining != '0)
                    && (!out_valid || out_ready);
    w_underrun_ev = (r_state == c_ST_POP) && !lifo_val && (r_remaining != '0)
                    && !out_valid;
    w_last_hs     = (r_state == c_ST_DRAIN) && out_valid && out_ready && out_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done <= w_zero_start || w_underrun_ev || w_last_hs;
      if (w_start_ok) begin
        r_remaining <= len;
      end else if (lifo_read) begin
        r_remaining <= r_remaining - c_CNT_ONE;
      end else if (w_underrun_ev) begin
        r_remaining <= '0;
      end
      if (w_start_ok || w_zero_start) begin
        r_underrun <= 1'b0;
      end else if (w_underrun_ev) begin
        r_underrun <= 1'b1;
      end
    end
  end

  lifo_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (lifo_read),
    .load_data (lifo_data),
    .load_last (w_rem_one),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .last      (out_last)
  );

  assign done     = r_done;
  assign underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_lifo_reader.sv
// ============================================================================
//  Module      : tb_lifo_reader
//  Description : Directed self-checking bench for lifo_reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lifo_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] len;
  logic       busy;
  logic       lifo_read;
  logic       lifo_val;
  logic [1:0] lifo_data;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       done;
  logic       underrun;

  int         checks;
  int         failures;

  logic [1:0] stack [0:5];
  int         sp;

  assign lifo_val  = (sp != 0);
  assign lifo_data = (sp != 0) ? stack[sp-1] : 2'd0;

  lifo_reader #(
    .DATA_W    (2),
    .LIFO_SIZE (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .lifo_read (lifo_read),
    .lifo_val  (lifo_val),
    .lifo_data (lifo_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; the LIFO model pops if lifo_read was high at the edge.
  task automatic tick();
    logic p;
    #1;
    p = lifo_read;
    @(posedge clk);
    #1;
    if (p && sp > 0) sp--;
    #1;
  endtask

  task automatic load3();
    stack[0] = 2'd1; stack[1] = 2'd2; stack[2] = 2'd3; sp = 3;
  endtask

  initial begin
    checks = 0; failures = 0; sp = 0;
    for (int i = 0; i < 6; i++) stack[i] = 2'd0;
    reset = 1'b0; start = 1'b0; len = 3'd0; out_ready = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_read", lifo_read, 0);
    check("rst_data", out_data, 0);
    reset = 1'b1;
    tick();

    // Burst of 3 with an ignored start while busy
    load3();
    start = 1'b1; len = 3'd3;
    tick();
    start = 1'b0; #1;
    check("a_busy", busy, 1);
    check("a_read1", lifo_read, 1);
    check("a_valid0", out_valid, 0);
    tick();
    start = 1'b1; len = 3'd1; #1;
    check("a_b1_valid", out_valid, 1);
    check("a_b1_data", out_data, 3);
    check("a_b1_last", out_last, 0);
    tick();
    check("a_b2_data", out_data, 2);
    check("a_b2_last", out_last, 0);
    tick();
    start = 1'b0; #1;
    check("a_b3_data", out_data, 1);
    check("a_b3_last", out_last, 1);
    check("a_b3_read", lifo_read, 0);
    check("a_b3_done", done, 0);
    tick();
    check("a_done", done, 1);
    check("a_end_valid", out_valid, 0);
    check("a_end_busy", busy, 0);
    check("a_underrun", underrun, 0);
    tick();
    check("a_done_pulse", done, 0);
    check("a_sp", sp, 0);

    // Backpressure for two cycles after the first beat
    load3();
    start = 1'b1; len = 3'd3;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b0; #1;
    check("b_b1_data", out_data, 3);
    check("b_stall_read0", lifo_read, 0);
    tick();
    check("b_hold_data", out_data, 3);
    check("b_hold_valid", out_valid, 1);
    check("b_stall_read1", lifo_read, 0);
    out_ready = 1'b1; #1;
    check("b_resume_read", lifo_read, 1);
    tick();
    check("b_b2_data", out_data, 2);
    check("b_b2_last", out_last, 0);
    tick();
    check("b_b3_data", out_data, 1);
    check("b_b3_last", out_last, 1);
    tick();
    check("b_done", done, 1);
    check("b_sp", sp, 0);

    // Underrun: LIFO holds 2,1 with 1 on top, len=4
    stack[0] = 2'd2; stack[1] = 2'd1; sp = 2;
    start = 1'b1; len = 3'd4;
    tick();
    start = 1'b0;
    tick();
    check("c_b1_data", out_data, 1);
    check("c_b1_last", out_last, 0);
    tick();
    check("c_b2_data", out_data, 2);
    check("c_b2_last", out_last, 0);
    check("c_b2_read", lifo_read, 0);
    tick();
    check("c_drained_valid", out_valid, 0);
    check("c_still_busy", busy, 1);
    check("c_not_yet", underrun, 0);
    tick();
    check("c_underrun", underrun, 1);
    check("c_done", done, 1);
    check("c_busy", busy, 0);
    check("c_valid", out_valid, 0);
    tick();
    check("c_done_pulse", done, 0);
    check("c_underrun_hold", underrun, 1);

    // Zero-length request
    start = 1'b1; len = 3'd0; #1;
    check("d_read", lifo_read, 0);
    tick();
    start = 1'b0; #1;
    check("d_done", done, 1);
    check("d_busy", busy, 0);
    check("d_valid", out_valid, 0);
    check("d_underrun_clr", underrun, 0);
    check("d_read2", lifo_read, 0);
    tick();
    check("d_done_pulse", done, 0);

    // Reset in the middle of a burst
    load3();
    start = 1'b1; len = 3'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("e_b2_data", out_data, 2);
    reset = 1'b0; #1;
    check("e_rst_valid", out_valid, 0);
    check("e_rst_read", lifo_read, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_data", out_data, 0);
    tick();
    reset = 1'b1;
    tick();
    check("e_post_valid", out_valid, 0);
    check("e_post_read", lifo_read, 0);
    check("e_post_busy", busy, 0);
    check("e_post_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
